maxhpc_fifo_wpack: RTL and testbench



---
 rtl/maxhpc_fifo_wpack.sv | 124 ++++++++++++
 tb/tb_maxhpc_fifo_wpack.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxhpc_fifo_wpack.sv
// Write-side packer: gathers RATIO narrow beats into one tagged FIFO word
// and throttles the source from the FIFO's write-side occupancy.
module maxhpc_fifo_wpack #(
    parameter int IN_WD        = 8,
    parameter int RATIO        = 4,
    parameter int CNT_WD       = $clog2(RATIO),
    parameter int DEPTH_WD     = 4,
    parameter int AFULL_MARGIN = 0,
    parameter int OUT_WD       = IN_WD*RATIO+CNT_WD+1
) (
    input  logic                wclk,
    input  logic                wclr,
    input  logic                i_valid,
    input  logic [IN_WD-1:0]    i_data,
    input  logic                i_last,
    output logic                i_ready,
    input  logic                i_flush,
    input  logic                f_wfull,
    input  logic [DEPTH_WD-1:0] f_wusedw,
    output logic                o_wr,
    output logic [OUT_WD-1:0]   o_d,
    output logic                o_stall,
    output logic [15:0]         o_wcnt
);

    localparam int DATA_WD = IN_WD*RATIO;
    localparam int FREE_WD = DEPTH_WD+2;

    typedef enum logic {FILL, HOLD} state_t;

    state_t              state, state_nxt;
    logic [CNT_WD-1:0]   lane, lane_nxt;
    logic [DATA_WD-1:0]  acc, acc_nxt, word_data;
    logic [OUT_WD-1:0]   held, held_nxt, word, d_nxt;
    logic                wr_nxt;
    logic [FREE_WD-1:0]  occ, free;
    logic                space, take, done, word_last;
    logic [CNT_WD-1:0]   word_cnt;

    // The in-flight write is not yet visible in wusedw, so reserve it here.
    assign occ   = FREE_WD'({f_wfull, f_wusedw});
    assign free  = FREE_WD'(1 << DEPTH_WD) - occ - FREE_WD'(o_wr);
    assign space = free > FREE_WD'(AFULL_MARGIN);

    assign i_ready = (state == FILL) && !wclr;
    assign o_stall = (state == HOLD);
    assign take    = i_valid && i_ready;

    always_comb begin
        word_data = acc;
        if (take) word_data[lane*IN_WD +: IN_WD] = i_data;
    end

    assign word_last = take && i_last;
    assign word_cnt  = take ? lane : lane - CNT_WD'(1);
    assign word      = {word_last, word_cnt, word_data};

    // A flush with a beat applies after that beat; alone it needs a partial word.
    always_comb begin
        done = 1'b0;
        if (state == FILL) begin
            if (take)
                done = (lane == CNT_WD'(RATIO-1)) || i_last || i_flush;
            else
                done = i_flush && (lane != '0);
        end
    end

    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        acc_nxt   = acc;
        held_nxt  = held;
        wr_nxt    = 1'b0;
        d_nxt     = o_d;
        unique case (state)
            FILL: begin
                if (done) begin
                    lane_nxt = '0;
                    acc_nxt  = '0;
                    if (space) begin
                        wr_nxt = 1'b1;
                        d_nxt  = word;
                    end else begin
                        held_nxt  = word;
                        state_nxt = HOLD;
                    end
                end else if (take) begin
                    lane_nxt = lane + CNT_WD'(1);
                    acc_nxt  = word_data;
                end
            end
            HOLD: begin
                if (space) begin
                    wr_nxt    = 1'b1;
                    d_nxt     = held;
                    lane_nxt  = '0;
                    state_nxt = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge wclk or posedge wclr) begin
        if (wclr) begin
            state  <= FILL;
            lane   <= '0;
            acc    <= '0;
            held   <= '0;
            o_wr   <= 1'b0;
            o_d    <= '0;
            o_wcnt <= '0;
        end else begin
            state  <= state_nxt;
            lane   <= lane_nxt;
            acc    <= acc_nxt;
            held   <= held_nxt;
            o_wr   <= wr_nxt;
            o_d    <= d_nxt;
            o_wcnt <= o_wcnt + 16'(o_wr);
        end
    end

endmodule

// File: tb/tb_maxhpc_fifo_wpack.sv
// Bench for maxhpc_fifo_wpack: directed cases plus random traffic checked
// against a queue-based packing model and a simple FIFO occupancy model.
module tb_maxhpc_fifo_wpack;

    localparam int IN_WD    = 8;
    localparam int RATIO    = 4;
    localparam int CNT_WD   = 2;
    localparam int DEPTH_WD = 4;
    localparam int MARGIN   = 0;
    localparam int DATA_WD  = IN_WD*RATIO;
    localparam int OUT_WD   = DATA_WD+CNT_WD+1;

    logic                wclk = 1'b0;
    logic                wclr = 1'b1;
    logic                i_valid = 1'b0;
    logic [IN_WD-1:0]    i_data = '0;
    logic                i_last = 1'b0;
    logic                i_ready;
    logic                i_flush = 1'b0;
    logic                f_wfull = 1'b0;
    logic [DEPTH_WD-1:0] f_wusedw = '0;
    logic                o_wr;
    logic [OUT_WD-1:0]   o_d;
    logic                o_stall;
    logic [15:0]         o_wcnt;

    maxhpc_fifo_wpack #(
        .IN_WD(IN_WD), .RATIO(RATIO), .DEPTH_WD(DEPTH_WD),
        .AFULL_MARGIN(MARGIN)
    ) dut (
        .wclk(wclk), .wclr(wclr),
        .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
        .i_ready(i_ready), .i_flush(i_flush),
        .f_wfull(f_wfull), .f_wusedw(f_wusedw),
        .o_wr(o_wr), .o_d(o_d), .o_stall(o_stall), .o_wcnt(o_wcnt)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;

    // FIFO occupancy as seen by the packer; writes land one edge after o_wr.
    int occ   = 0;
    bit track = 0;
    bit rd_en = 0;

    // Reference model: beats of the open word, a pending word, output regs.
    int                cur[$];
    bit                m_pend = 0;
    logic [OUT_WD-1:0] m_held = '0;
    bit                m_wr = 0;
    logic [OUT_WD-1:0] m_d = '0;
    logic [15:0]       m_wcnt = '0;
    logic [15:0]       base;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_WD-1:0] pack(bit last);
        logic [DATA_WD-1:0] data;
        data = '0;
        for (int i = 0; i < cur.size(); i++)
            data |= DATA_WD'(cur[i]) << (i*IN_WD);
        return {last, CNT_WD'(cur.size()-1), data};
    endfunction

    task automatic model_step();
        int                fr;
        bit                space;
        bit                tk;
        bit                dn;
        bit                nw;
        int                rd;
        logic [OUT_WD-1:0] nd;
        nw = 0;
        nd = '0;
        fr = (16 - occ - int'(m_wr)) & 63;
        space = fr > MARGIN;
        if (m_pend) begin
            if (space) begin
                nw = 1;
                nd = m_held;
                m_pend = 0;
            end
        end else begin
            tk = i_valid;
            if (tk) cur.push_back(int'(i_data));
            if (tk) dn = (cur.size() == RATIO) || i_last || i_flush;
            else    dn = i_flush && (cur.size() > 0);
            if (dn) begin
                nd = pack(tk && i_last);
                cur.delete();
                if (space) nw = 1;
                else begin
                    m_pend = 1;
                    m_held = nd;
                end
            end
        end
        rd = (rd_en && occ > 0 && $urandom_range(2) == 0) ? 1 : 0;
        if (track) occ = occ + int'(m_wr) - rd;
        m_wcnt += 16'(m_wr);
        m_wr = nw;
        if (nw) m_d = nd;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit l,
                        input bit f);
        @(negedge wclk);
        check("i_ready", i_ready, !m_pend);
        check("o_stall", o_stall, m_pend);
        check("o_wr", o_wr, m_wr);
        check("o_d", o_d, m_d);
        check("o_wcnt", o_wcnt, m_wcnt);
        check("occ_bound", occ <= 16, 1);
        i_valid  = v;
        i_data   = d;
        i_last   = l;
        i_flush  = f;
        f_wfull  = occ >= 16;
        f_wusedw = DEPTH_WD'(occ);
        model_step();
    endtask

    task automatic chk_reset();
        check("rst_ready", i_ready, 0);
        check("rst_wr", o_wr, 0);
        check("rst_d", o_d, 0);
        check("rst_stall", o_stall, 0);
        check("rst_wcnt", o_wcnt, 0);
    endtask

    task automatic after_edge();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        #1;
        chk_reset();
        @(negedge wclk);
        wclr = 1'b0;

        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 1, 0);
        after_edge();
        check("tp_full_wr", o_wr, 1);
        check("tp_full_d", o_d, {1'b1, 2'd3, 32'h44332211});

        step(1, 8'hA1, 0, 0);
        step(1, 8'hA2, 1, 0);
        after_edge();
        check("tp_short_d", o_d, {1'b1, 2'd1, 32'h0000A2A1});

        step(1, 8'h5C, 0, 0);
        step(0, 8'h00, 0, 1);
        after_edge();
        check("tp_flush_wr", o_wr, 1);
        check("tp_flush_d", o_d, {1'b0, 2'd0, 32'h0000005C});
        step(0, 8'h00, 0, 1);
        after_edge();
        check("tp_flush_empty", o_wr, 0);

        occ = 16;
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h04, 1, 0);
        after_edge();
        check("tp_hold_stall", o_stall, 1);
        check("tp_hold_ready", i_ready, 0);
        check("tp_hold_wr", o_wr, 0);
        step(1, 8'h77, 1, 1);
        occ = 15;
        step(0, 8'h00, 0, 0);
        after_edge();
        check("tp_release_wr", o_wr, 1);
        check("tp_release_d", o_d, {1'b1, 2'd3, 32'h04030201});
        step(0, 8'h00, 0, 0);
        after_edge();
        check("tp_release_fill", o_stall, 0);

        occ = 14;
        track = 1;
        base = m_wcnt;
        repeat (6) step(1, 8'($urandom), 1, 0);
        after_edge();
        check("tp_margin_writes", o_wcnt - base, 2);
        check("tp_margin_stall", o_stall, 1);
        track = 0;
        occ = 0;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);

        step(1, 8'hB1, 0, 0);
        step(1, 8'hB2, 0, 0);
        @(negedge wclk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_flush = 1'b0;
        wclr    = 1'b1;
        #1;
        chk_reset();
        cur.delete();
        m_pend = 0;
        m_wr   = 0;
        m_d    = '0;
        m_wcnt = '0;
        #2;
        wclr = 1'b0;
        step(1, 8'hC1, 0, 0);
        step(1, 8'hC2, 0, 0);
        step(1, 8'hC3, 0, 0);
        step(1, 8'hC4, 0, 0);
        after_edge();
        check("tp_reset_d", o_d, {1'b0, 2'd3, 32'hC4C3C2C1});

        track = 1;
        rd_en = 1;
        repeat (3000)
            step($urandom_range(9) < 7, 8'($urandom),
                 $urandom_range(4) == 0, $urandom_range(9) == 0);
        rd_en = 0;
        repeat (4) step(0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
